// File: rtl/fetch_stage_pkg.sv
// Shared widths, defaults and the queue entry type for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int unsigned InstrMemWidth = 32;
    localparam int unsigned InstrWidth    = 32;
    localparam int unsigned EntryWidth    = InstrMemWidth + InstrWidth;
    localparam int unsigned FetchQdepth   = 2;

    localparam logic [InstrMemWidth-1:0] ResetPcDefault = '0;

    typedef struct packed {
        logic [InstrMemWidth-1:0] pc;
        logic [InstrWidth-1:0]    instr;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input logic [InstrMemWidth-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port plus the valid/ready handshake toward decode.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic [InstrMemWidth-1:0] instr_addr;
    logic                     re;
    logic [InstrWidth-1:0]    instr;

    logic                     out_valid;
    logic                     out_ready;
    logic [InstrWidth-1:0]    out_instr;
    logic [InstrMemWidth-1:0] out_pc;

    modport master (
        output instr_addr, re, out_valid, out_instr, out_pc,
        input  instr, out_ready
    );

    modport slave (
        input  instr_addr, re, out_valid, out_instr, out_pc,
        output instr, out_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries with a flush that drops all queued entries.
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int unsigned DEPTH = FetchQdepth
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_entry_t      mem_q [DEPTH];
    fetch_entry_t      mem_d [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (flush) begin
            wr_ptr_d = rd_ptr_d;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads instruction memory, queues {pc, instr} toward
// decode, and flushes on redirects while trapping misaligned redirect targets.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [InstrMemWidth-1:0] RESET_PC = ResetPcDefault,
    parameter int unsigned              QDEPTH   = FetchQdepth
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     redirect,
    input  logic [InstrMemWidth-1:0] redirect_pc,
    fetch_stage_if.master            bus,
    output logic                     fault,
    output logic [InstrMemWidth-1:0] fault_pc
);

    localparam int unsigned CntW = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StFault
    } state_e;

    state_e                   state_q, state_d;
    logic [InstrMemWidth-1:0] pc_q, pc_d;
    logic [InstrMemWidth-1:0] fault_pc_q, fault_pc_d;

    logic                     re;
    logic                     push;
    logic                     pop;
    logic                     push_ok;
    logic                     q_full;
    logic                     q_empty;
    logic [CntW-1:0]          q_count;
    fetch_entry_t             q_head;
    fetch_entry_t             q_wdata;

    assign pop     = bus.out_valid & bus.out_ready;
    assign push_ok = (q_count < CntW'(QDEPTH)) | pop;
    assign q_wdata = '{pc: pc_q, instr: bus.instr};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        re         = 1'b0;

        case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: begin
                re = push_ok;
                if (push_ok) begin
                    pc_d = pc_q + InstrMemWidth'(4);
                end
            end
            StFault: ;
            default: state_d = StIdle;
        endcase

        // Redirect overrides any fetch this cycle; the fetched word is dropped by the flush.
        push = re & ~redirect;
        if (redirect) begin
            pc_d = redirect_pc;
            if (is_word_aligned(redirect_pc)) begin
                state_d = StFetch;
            end else begin
                state_d    = StFault;
                fault_pc_d = redirect_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .wdata (q_wdata),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign bus.instr_addr = pc_q;
    assign bus.re         = re;
    assign bus.out_valid  = ~q_empty;
    assign bus.out_pc     = q_head.pc;
    assign bus.out_instr  = q_head.instr;
    assign fault          = (state_q == StFault);
    assign fault_pc       = fault_pc_q;

    full_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
        q_full == (q_count == CntW'(QDEPTH)));

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage directly upstream of the instruction memory. Owns the program counter, drives the memory's address and read-enable, captures the combinationally returned instruction word, and buffers {pc, instr} pairs in a small queue toward decode with a valid/ready handshake. Handles control-flow redirects (branch/jump/exception vector) with queue flush, and traps misaligned redirect targets.

## Interface

- RESET_PC, 0, byte address loaded into the PC on reset; must be 4-byte aligned
- QDEPTH, 2, fetch queue entries (power of two, ≥2)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- redirect  in  1  load redirect_pc into PC and flush queue
- redirect_pc  in  `INSTR_MEM_WIDTH  redirect target, byte address
- instr_addr  out  `INSTR_MEM_WIDTH  byte address to instruction memory (= PC)
- re  out  1  read enable to instruction memory
- instr  in  `INSTR_WIDTH  instruction word returned combinationally for instr_addr
- out_valid  out  1  queue head valid toward decode
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  `INSTR_WIDTH  head instruction
- out_pc  out  `INSTR_MEM_WIDTH  head PC
- fault  out  1  misaligned redirect trapped; fetch halted
- fault_pc  out  `INSTR_MEM_WIDTH  offending redirect target

## Operation

- Reset values: PC=RESET_PC, state IDLE, queue empty, re=0, out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0. instr_addr tracks PC.
- FSM states: IDLE, FETCH, FAULT.
  - IDLE: re=0 for exactly one cycle after reset release, then -> FETCH. A redirect in IDLE is honoured (aligned -> FETCH, misaligned -> FAULT).
  - FETCH: re=1 iff push allowed = (count<QDEPTH) or (out_valid & out_ready). On re=1 and no redirect: push {PC, instr}, PC <= PC+4, wrapping modulo 2^`INSTR_MEM_WIDTH.
  - FAULT: re=0, PC frozen, fault=1. Exits only on an aligned redirect -> FETCH, fault cleared. Misaligned redirect in FAULT stays in FAULT and updates fault_pc.
- Redirect (any state) has priority over fetch: queue count <= 0, same-cycle push discarded, PC <= redirect_pc. Same-cycle head pop (out_valid & out_ready) is a completed transfer to decode. If redirect_pc[1:0]≠0 -> FAULT, fault_pc <= redirect_pc.
- Queue: FIFO ordered by fetch; out_valid = (count≠0); head fields hold last value when empty (not required 0 after first fill). Simultaneous push and pop when full is legal; count unchanged.
- No combinational path from out_ready to out_valid/out_instr/out_pc; re and instr_addr may depend combinationally on out_ready.

## Timing

- Fetch-to-decode latency: word fetched in cycle N (re=1) appears at queue head in N+1 if queue was empty.
- Sustained throughput: one instruction per cycle with out_ready held high.
- First re=1 in cycle 2 after rst_n rises (cycle 1 = IDLE).
- Redirect in cycle N: out_valid=0 in N+1; first fetch of target in N+1; target at head in N+2.
- Backpressure: with out_ready=0, re drops the cycle after the queue reaches QDEPTH; PC holds.
- Asynchronous reset mid-operation: all state returns to reset values immediately; any partially queued entries are lost.

## Structure

- Shared defines in common.vh: `INSTR_MEM_WIDTH, `INSTR_WIDTH (existing), plus new `RESET_PC_DEFAULT and `FETCH_QDEPTH.
- FSM state encodings: local parameters inside fetch_stage.
- Sub-module fetch_queue: synchronous FIFO with flush input, parameter DEPTH, data width `INSTR_WIDTH+`INSTR_MEM_WIDTH, push/pop/full/empty/count ports.
- Bench instantiates fetch_stage together with the instruction memory, preloading a known hex image.

## Test plan

- Reset and stream: image word k = 0x1000_0000+k, out_ready=1 -> re=1 from cycle 2; outputs (pc,instr) = (0,0x10000000),(4,0x10000001),(8,…) one per cycle, no gaps.
- Backpressure: out_ready=0 from cycle 3 -> count reaches 2, re=0, PC held at 8; out_ready=1 -> entries pc 0,4 drained in order, then pc 8 follows with no loss or duplication.
- Redirect flush: with 2 entries queued, redirect=1, redirect_pc=0x40 -> out_valid=0 next cycle, next output pc=0x40 with word 16, no stale entries.
- Misaligned redirect: redirect_pc=0x42 -> fault=1, fault_pc=0x42, re=0 held for 10 cycles; then redirect_pc=0x80 -> fault=0, output pc=0x80 two cycles later.
- Wrap-around: redirect to (2^`INSTR_MEM_WIDTH)−4 -> outputs that pc then pc 0.
- Async reset mid-stream: rst_n low asynchronously between edges -> out_valid, re, fault drop immediately, PC=RESET_PC; restart matches reset scenario.
